// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory-latch port between the I-cache and
// the D-cache, one 256-bit line transaction at a time.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   i_read/i_address     I-cache line read request
//   i_resp/i_rdata       I-cache completion and read line
//   d_read/d_write       D-cache line read / write request
//   d_address/d_wdata    D-cache line address and write line
//   d_resp/d_rdata       D-cache completion and read line
//   mem_read/mem_write   registered command to the memory latch
//   mem_address          registered line address to the memory latch
//   mem_wdata            registered write line to the memory latch
//   mem_resp/mem_rdata   completion and read line from the memory latch
//
// Parameter RELEASE_CYCLES (2..15): idle gap after every response.
// Macro CACHE_ARB_ROUND_ROBIN_EN: alternate grants when both caches
// contend; when undefined the D-cache always wins a contest.
module cache_mem_arbiter #(
    parameter int RELEASE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic         i_resp,
    output logic [255:0] i_rdata,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic         d_resp,
    output logic [255:0] d_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_address,
    output logic [255:0] mem_wdata,
    input  logic         mem_resp,
    input  logic [255:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE
    } state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic           mem_read_q;
    logic           mem_write_q;
    logic [31:0]    addr_q;
    logic [255:0]   wdata_q;
    logic           d_req;
    logic           d_wins;

    assign d_req = d_read | d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // last_d_q: 1 when the most recent grant went to the D-cache.
    logic last_d_q;
    assign d_wins = d_req & (~i_read | ~last_d_q);
`else
    assign d_wins = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 256'd0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (d_wins) begin
                        state_q     <= SERVE_D;
                        addr_q      <= d_address;
                        wdata_q     <= d_wdata;
                        // simultaneous read+write is served as a write
                        mem_write_q <= d_write;
                        mem_read_q  <= ~d_write;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                        last_d_q    <= 1'b1;
`endif
                    end else if (i_read) begin
                        state_q     <= SERVE_I;
                        addr_q      <= i_address;
                        mem_read_q  <= 1'b1;
                        mem_write_q <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                        last_d_q    <= 1'b0;
`endif
                    end
                end
                SERVE_I, SERVE_D: begin
                    // runs to completion even if the cache drops its request
                    if (mem_resp) begin
                        state_q     <= RELEASE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        cnt_q       <= 4'(RELEASE_CYCLES);
                    end
                end
                RELEASE: begin
                    // gap lets the latch's delayed command copy drain
                    if (cnt_q <= 4'd1) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

    assign i_resp  = (state_q == SERVE_I) & mem_resp;
    assign d_resp  = (state_q == SERVE_D) & mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
